// File: rtl/band_capture_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// band_capture_if : control, sample-stream and read-port bundle for band_capture
// Rev 1.0
// ---------------------------------------------------------------------------
interface band_capture_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                    start;
    logic                    stop;
    logic                    valid_in;
    logic signed [15:0]      data_in;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic signed [15:0]      rd_data;
    logic                    rd_valid;
    logic                    busy;
    logic                    done;
    logic [ADDR_WIDTH:0]     wr_count;
    logic [ADDR_WIDTH-1:0]   first_addr;

    modport master (
        output start, stop, valid_in, data_in, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, done, wr_count, first_addr
    );

    modport slave (
        input  start, stop, valid_in, data_in, rd_en, rd_addr,
        output rd_data, rd_valid, busy, done, wr_count, first_addr
    );
endinterface
`default_nettype wire

// File: rtl/band_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// band_capture : arm/trigger/record FSM writing 16-bit samples into a buffer
//                with a registered read port. BAND_CAPTURE_LOOP_EN = ring mode.
// Rev 1.0
// ---------------------------------------------------------------------------
module band_capture #(
    parameter int MEM_DEPTH  = 4036,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int THRESH     = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    band_capture_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_RECORD = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    localparam logic [16:0]           THRESH_MAG = 17'(THRESH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH:0]     wr_count_q, wr_count_d;
    logic [ADDR_WIDTH-1:0]   first_addr_q, first_addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic signed [15:0]      rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;

    logic signed [15:0]      mem [MEM_DEPTH];
    logic                    wr_en;
    logic [16:0]             sample_mag;
    logic [17:0]             mag_diff;
    logic                    trig_hit;

    // 17-bit magnitude so that -32768 becomes +32768 rather than overflowing
    assign sample_mag = bus.data_in[15] ? (17'd0 - {1'b1, bus.data_in})
                                        : {1'b0, bus.data_in};
    assign mag_diff   = {1'b0, sample_mag} - {1'b0, THRESH_MAG};
    assign trig_hit   = ~mag_diff[17];

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        wr_count_d   = wr_count_q;
        first_addr_d = first_addr_q;
        wr_en        = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (bus.valid_in && trig_hit) begin
                    wr_en   = 1'b1;
                    state_d = S_RECORD;
                end
                if (bus.stop) begin
                    state_d = S_DONE;
                end
            end
            S_RECORD: begin
                wr_en = bus.valid_in;
                if (bus.stop) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            wr_addr_d  = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
            wr_count_d = (wr_count_q == FULL_COUNT) ? FULL_COUNT : wr_count_q + 1'b1;
`ifdef BAND_CAPTURE_LOOP_EN
            // Once full, the oldest sample sits right where the next write lands
            if (wr_count_d == FULL_COUNT) begin
                first_addr_d = wr_addr_d;
            end
`else
            if (wr_count_d == FULL_COUNT) begin
                state_d = S_DONE;
            end
`endif
        end

        if ((state_d == S_ARMED) && (state_q != S_ARMED)) begin
            wr_addr_d    = '0;
            wr_count_d   = '0;
            first_addr_d = '0;
        end
    end

    assign busy_d = (state_d == S_ARMED) || (state_d == S_RECORD);
    assign done_d = (state_d == S_DONE);

    // Combinational read of the pre-edge array gives old-data on same-address collisions
    always_comb begin
        rd_data_d = rd_data_q;
        if (bus.rd_en) begin
            rd_data_d = mem[bus.rd_addr];
        end
    end

    assign rd_valid_d = bus.rd_en;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            wr_count_q   <= '0;
            first_addr_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            wr_count_q   <= wr_count_d;
            first_addr_q <= first_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wr_count   = wr_count_q;
    assign bus.first_addr = first_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_band_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_band_capture : two band_capture instances (THRESH 0 and 100) driven in
//                   lock-step and compared each cycle with a behavioural model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_band_capture;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
`ifdef BAND_CAPTURE_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_REC   = 2;
    localparam int M_DONE  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic              start    = 1'b0;
    logic              stop     = 1'b0;
    logic              valid_in = 1'b0;
    logic signed [15:0] data_in = '0;
    logic              rd_en    = 1'b0;
    logic [AW-1:0]     rd_addr  = '0;

    band_capture_if #(.ADDR_WIDTH(AW)) bus0 ();
    band_capture_if #(.ADDR_WIDTH(AW)) bus1 ();

    assign bus0.start = start;   assign bus1.start = start;
    assign bus0.stop = stop;     assign bus1.stop = stop;
    assign bus0.valid_in = valid_in; assign bus1.valid_in = valid_in;
    assign bus0.data_in = data_in;   assign bus1.data_in = data_in;
    assign bus0.rd_en = rd_en;       assign bus1.rd_en = rd_en;
    assign bus0.rd_addr = rd_addr;   assign bus1.rd_addr = rd_addr;

    band_capture #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .THRESH(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    band_capture #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .THRESH(100)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    always #5 clk = ~clk;

    logic [1:0]         o_busy, o_done, o_rv;
    logic [AW:0]        o_cnt [2];
    logic [AW-1:0]      o_first [2];
    logic signed [15:0] o_rd [2];

    assign o_busy  = {bus1.busy, bus0.busy};
    assign o_done  = {bus1.done, bus0.done};
    assign o_rv    = {bus1.rd_valid, bus0.rd_valid};
    assign o_cnt[0] = bus0.wr_count;     assign o_cnt[1] = bus1.wr_count;
    assign o_first[0] = bus0.first_addr; assign o_first[1] = bus1.first_addr;
    assign o_rd[0] = bus0.rd_data;       assign o_rd[1] = bus1.rd_data;

    // Reference model: one record per instance
    int thr [2] = '{0, 100};
    int m_state [2];
    int m_wa [2];
    int m_cnt [2];
    int m_first [2];
    int m_mem [2][DEPTH];
    bit m_known [2][DEPTH];
    int m_rd [2];
    bit m_rd_known [2];
    bit m_rv [2];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_state[k] = M_IDLE;
            m_wa[k] = 0; m_cnt[k] = 0; m_first[k] = 0;
            m_rd[k] = 0; m_rd_known[k] = 1'b1; m_rv[k] = 1'b0;
        end
    endtask

    task automatic arm(input int k);
        m_state[k] = M_ARMED;
        m_wa[k] = 0; m_cnt[k] = 0; m_first[k] = 0;
    endtask

    task automatic capture(input int k, input int d);
        m_mem[k][m_wa[k]]   = d;
        m_known[k][m_wa[k]] = 1'b1;
        m_wa[k] = (m_wa[k] + 1) % DEPTH;
        if (m_cnt[k] < DEPTH) m_cnt[k]++;
        if (m_cnt[k] == DEPTH) begin
            if (LOOP) m_first[k] = m_wa[k];
            else      m_state[k] = M_DONE;
        end
    endtask

    task automatic model_edge(input int k);
        int d;
        int mag;
        if (rd_en) begin
            m_rd[k]       = m_mem[k][rd_addr];
            m_rd_known[k] = m_known[k][rd_addr];
        end
        m_rv[k] = rd_en;
        d   = int'(data_in);
        mag = (d < 0) ? -d : d;
        case (m_state[k])
            M_IDLE, M_DONE: if (start) arm(k);
            M_ARMED: begin
                if (valid_in && mag >= thr[k]) begin
                    m_state[k] = M_REC;
                    capture(k, d);
                end
                if (stop) m_state[k] = M_DONE;
            end
            M_REC: begin
                if (valid_in) capture(k, d);
                if (stop) m_state[k] = M_DONE;
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", k), int'(o_busy[k]),
                int'(m_state[k] == M_ARMED || m_state[k] == M_REC));
            chk($sformatf("done%0d", k), int'(o_done[k]), int'(m_state[k] == M_DONE));
            chk($sformatf("wr_count%0d", k), int'(o_cnt[k]), m_cnt[k]);
            chk($sformatf("first_addr%0d", k), int'(o_first[k]), m_first[k]);
            chk($sformatf("rd_valid%0d", k), int'(o_rv[k]), int'(m_rv[k]));
            if (m_rd_known[k])
                chk($sformatf("rd_data%0d", k), int'(o_rd[k]), m_rd[k]);
        end
    endtask

    task automatic step(input bit s, input bit p, input bit v, input int d,
                        input bit re, input int ra);
        start = s; stop = p; valid_in = v; data_in = 16'(d);
        rd_en = re; rd_addr = AW'(ra);
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        compare_all();
        start = 1'b0; stop = 1'b0; valid_in = 1'b0; rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic strobe(input int d);
        idle(2);
        step(0, 0, 1, d, 0, 0);
    endtask

    task automatic rd(input int a);
        step(0, 0, 0, 0, 1, a);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_busy", int'(o_busy[0]), 0);
        chk("rst_done", int'(o_done[0]), 0);
        chk("rst_count", int'(o_cnt[0]), 0);
        @(posedge clk);
        #1;
        compare_all();
        rst_n = 1'b1;
    endtask

    int exp4 [DEPTH];

    initial begin
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < DEPTH; a++) begin
                m_mem[k][a] = 0;
                m_known[k][a] = 1'b0;
            end
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: plain capture 1..8 and readback
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) strobe(i);
`ifndef BAND_CAPTURE_LOOP_EN
        chk("t1_done", int'(o_done[0]), 1);
`endif
        chk("t1_count", int'(o_cnt[0]), DEPTH);
        for (int a = 0; a < DEPTH; a++) begin
            rd(a);
            chk("t1_rd_valid", int'(o_rv[0]), 1);
            chk("t1_rd_data", int'(o_rd[0]), a + 1);
        end
        idle(1);
        chk("t1_rd_valid_drop", int'(o_rv[0]), 0);

        // 2: amplitude trigger on the THRESH=100 instance
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        strobe(5); strobe(-50); strobe(-100); strobe(7);
        chk("t2_count", int'(o_cnt[1]), 2);
        rd(0);
        chk("t2_mem0", int'(o_rd[1]), -100);
        rd(1);
        chk("t2_mem1", int'(o_rd[1]), 7);
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        strobe(-32768);
        chk("t2_min_count", int'(o_cnt[1]), 1);
        rd(0);
        chk("t2_min_data", int'(o_rd[1]), -32768);

        // 3: stop coincident with a strobe
        step(0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        strobe(1); strobe(2);
        idle(2);
        step(0, 1, 1, 3, 0, 0);
        chk("t3_count", int'(o_cnt[0]), 3);
        chk("t3_done", int'(o_done[0]), 1);
        strobe(4); strobe(5);
        chk("t3_count_hold", int'(o_cnt[0]), 3);
        rd(2);
        chk("t3_mem2", int'(o_rd[0]), 3);

        // 4: eleven strobes then stop
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 11; i++) strobe(i);
        step(0, 1, 0, 0, 0, 0);
        chk("t4_count", int'(o_cnt[0]), DEPTH);
`ifdef BAND_CAPTURE_LOOP_EN
        chk("t4_first", int'(o_first[0]), 3);
        exp4 = '{9, 10, 11, 4, 5, 6, 7, 8};
`else
        chk("t4_first", int'(o_first[0]), 0);
        exp4 = '{1, 2, 3, 4, 5, 6, 7, 8};
`endif
        for (int a = 0; a < DEPTH; a++) begin
            rd(a);
            chk("t4_mem", int'(o_rd[0]), exp4[a]);
        end

        // 5: reset mid-capture, then a clean capture
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) strobe(i * 10);
        async_reset();
        step(1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) strobe(-i);
        chk("t5_count", int'(o_cnt[0]), DEPTH);
`ifndef BAND_CAPTURE_LOOP_EN
        chk("t5_done", int'(o_done[0]), 1);
`endif

        // 6: start+stop from DONE re-arms; start during RECORD is ignored
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("t6_busy", int'(o_busy[0]), 1);
        chk("t6_count", int'(o_cnt[0]), 0);
        strobe(1); strobe(2); strobe(3);
        step(1, 0, 0, 0, 0, 0);
        chk("t6_count_keep", int'(o_cnt[0]), 3);
        step(1, 0, 1, 4, 0, 0);
        chk("t6_count_inc", int'(o_cnt[0]), 4);

        // Randomised traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int d;
            case ($urandom % 8)
                0: d = -32768;
                1: d = 32767;
                2: d = 100;
                3: d = -100;
                4: d = ($urandom % 2) ? 99 : -99;
                default: d = int'($urandom % 65536) - 32768;
            endcase
            if ($urandom % 600 == 0) async_reset();
            step(($urandom % 24) == 0, ($urandom % 40) == 0, ($urandom % 3) == 0, d,
                 ($urandom % 2) == 0, int'($urandom % DEPTH));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
